// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : stall/bubble/flush generation for the 5-stage RV64I pipeline
// Rev 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW        = 5,
  parameter int REDIR_BUBBLES = 2,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_redirect_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_hold_o,
  output logic              ifid_hold_o,
  output logic              ifid_flush_o,
  output logic              idex_hold_o,
  output logic              idex_bubble_o,
  output logic              exmem_hold_o,
  output logic              memwb_bubble_o,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int DW = (REDIR_BUBBLES > 1) ? $clog2(REDIR_BUBBLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [DW-1:0] C_DRAIN_LOAD = DW'(REDIR_BUBBLES - 1);
  localparam logic [WW-1:0] C_WAIT_MAX   = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d, base_st;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             saved_drain_q, saved_drain_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             memwait, load_use, any_hold;

  assign memwait  = ((state_q == ST_MEM_WAIT) || mem_req_i) && !mem_ack_i;
  assign load_use = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && id_valid_i &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    saved_drain_d  = saved_drain_q;
    timeout_d      = timeout_q;
    pc_hold_o      = 1'b0;
    ifid_hold_o    = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_hold_o    = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    // On the ack cycle the pipeline resumes in whatever mode was frozen, so a
    // pending drain squashes ID right away instead of letting it reach EX.
    base_st = state_q;
    if (state_q == ST_MEM_WAIT) begin
      base_st = (saved_drain_q && (drain_cnt_q != '0)) ? ST_DRAIN : ST_RUN;
    end

    if (memwait) begin
      pc_hold_o      = 1'b1;
      ifid_hold_o    = 1'b1;
      idex_hold_o    = 1'b1;
      exmem_hold_o   = 1'b1;
      memwb_bubble_o = 1'b1;
      state_d        = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        saved_drain_d = (state_q == ST_DRAIN);
      end
      if (wait_cnt_q != C_WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end
      if (wait_cnt_d == C_WAIT_MAX) begin
        timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d    = '0;
      saved_drain_d = 1'b0;
      state_d       = base_st;
      if (ex_redirect_i) begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        if (REDIR_BUBBLES > 1) begin
          drain_cnt_d = C_DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else begin
          drain_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end else if (base_st == ST_DRAIN) begin
        ifid_flush_o = 1'b1;
        drain_cnt_d  = drain_cnt_q - DW'(1);
        if (drain_cnt_d == '0) begin
          state_d = ST_RUN;
        end
      end else if (load_use) begin
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
        idex_bubble_o = 1'b1;
      end
    end

    if (rst_i) begin
      pc_hold_o      = 1'b0;
      ifid_hold_o    = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_hold_o    = 1'b0;
      idex_bubble_o  = 1'b0;
      exmem_hold_o   = 1'b0;
      memwb_bubble_o = 1'b0;
    end
  end

  assign any_hold = pc_hold_o || ifid_hold_o || idex_hold_o || exmem_hold_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      saved_drain_q <= 1'b0;
      timeout_q     <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      saved_drain_q <= saved_drain_d;
      timeout_q     <= timeout_d;
      if (any_hold && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int RB   = 2;
  localparam int TO   = 8;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_RED  = 7'b0010100;
  localparam logic [6:0] C_DRN  = 7'b0010000;
  localparam logic [6:0] C_WAIT = 7'b1101011;

  localparam int M_RUN = 0, M_DRAIN = 1, M_WAIT = 2;

  typedef struct {
    logic          rst, idv, u1, u2, exv, ld, redir, req, ack;
    logic [AW-1:0] rs1, rs2, rd;
  } in_t;

  typedef struct {
    in_t        stim;
    logic [6:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, idv, u1, u2, exv, ld, redir, req, ack;
  logic [AW-1:0] rs1, rs2, rd;
  logic          pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble;
  logic          timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctrl;

  int total = 0;
  int bad   = 0;

  int m_mode, m_drain, m_wait, m_stall, m_flush;
  bit m_saved, m_to;

  vec_t vq[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .REDIR_BUBBLES(RB), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(idv), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_use_rs1_i(u1), .id_use_rs2_i(u2),
    .ex_valid_i(exv), .ex_rd_i(rd), .ex_mem_read_i(ld), .ex_redirect_i(redir),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold), .ifid_flush_o(ifid_flush),
    .idex_hold_o(idex_hold), .idex_bubble_o(idex_bubble), .exmem_hold_o(exmem_hold),
    .memwb_bubble_o(memwb_bubble), .mem_timeout_o(timeout),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble};

  function automatic in_t mk(bit r, bit iv, int s1, int s2, bit a1, bit a2,
                             bit ev, int d, bit l, bit rd_x, bit rq, bit ak);
    in_t v;
    v.rst = r;   v.idv = iv;  v.rs1 = AW'(s1); v.rs2 = AW'(s2);
    v.u1  = a1;  v.u2  = a2;  v.exv = ev;      v.rd  = AW'(d);
    v.ld  = l;   v.redir = rd_x; v.req = rq;   v.ack = ak;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic in_t waitv();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; idv = v.idv; rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2;
    exv = v.exv; rd = v.rd; ld = v.ld; redir = v.redir; req = v.req; ack = v.ack;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input in_t v, input logic [6:0] exp, input string tag);
    drive(v);
    @(negedge clk);
    chk(tag, 32'(ctrl), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_t v;
    v = idle();
    v.rst = 1'b1;
    drive(v);
    @(posedge clk); #1;
  endtask

  task automatic model_step(input in_t v, output logic [6:0] e);
    bit pc, ih, fl, xh, bb, mh, wb, hit;
    int base;
    logic [AW-1:0] srcs[$];
    pc = 0; ih = 0; fl = 0; xh = 0; bb = 0; mh = 0; wb = 0; hit = 0;
    if (v.rst) begin
      m_mode = M_RUN; m_drain = 0; m_wait = 0; m_saved = 0; m_to = 0;
      m_stall = 0; m_flush = 0;
      e = '0;
      return;
    end
    if ((m_mode == M_WAIT || v.req) && !v.ack) begin
      pc = 1; ih = 1; xh = 1; mh = 1; wb = 1;
      if (m_mode != M_WAIT) m_saved = (m_mode == M_DRAIN);
      m_mode = M_WAIT;
      m_wait++;
      if (m_wait >= TO) m_to = 1;
    end else begin
      base = m_mode;
      if (m_mode == M_WAIT) base = (m_saved && m_drain > 0) ? M_DRAIN : M_RUN;
      m_wait = 0;
      m_mode = base;
      if (v.redir) begin
        fl = 1; bb = 1;
        m_drain = RB - 1;
        m_mode  = (RB > 1) ? M_DRAIN : M_RUN;
      end else if (base == M_DRAIN) begin
        fl = 1;
        m_drain--;
        if (m_drain == 0) m_mode = M_RUN;
      end else begin
        if (v.u1) srcs.push_back(v.rs1);
        if (v.u2) srcs.push_back(v.rs2);
        if (v.exv && v.ld && v.rd != 0 && v.idv)
          foreach (srcs[i]) if (srcs[i] == v.rd) hit = 1;
        if (hit) begin pc = 1; ih = 1; bb = 1; end
      end
    end
    if ((pc || ih || xh || mh) && m_stall < CMAX) m_stall++;
    if (fl && m_flush < CMAX) m_flush++;
    e = {pc, ih, fl, xh, bb, mh, wb};
  endtask

  initial begin
    vec_t vv;
    in_t  v;
    logic [6:0] e;

    do_reset();
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_flush", 32'(flush_cnt), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;

    // single-cycle vectors, each applied from a freshly reset RUN state
    vv.stim = mk(0,1,5,0,1,0,1,5,1,0,0,0); vv.exp = C_LU;   vq.push_back(vv);
    vv.stim = mk(0,1,0,5,0,1,1,5,1,0,0,0); vv.exp = C_LU;   vq.push_back(vv);
    vv.stim = mk(0,1,0,0,1,1,1,0,1,0,0,0); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,1,5,5,1,1,1,5,0,0,0,0); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,1,5,5,1,1,0,5,1,0,0,0); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,0,5,5,1,1,1,5,1,0,0,0); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,1,5,5,0,0,1,5,1,0,0,0); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,1,5,6,0,1,1,5,1,0,0,0); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,0,0,0,0,0,0,0,0,1,0,0); vv.exp = C_RED;  vq.push_back(vv);
    vv.stim = mk(0,1,5,0,1,0,1,5,1,1,0,0); vv.exp = C_RED;  vq.push_back(vv);
    vv.stim = mk(0,1,5,0,1,0,1,5,1,1,1,0); vv.exp = C_WAIT; vq.push_back(vv);
    vv.stim = mk(0,0,0,0,0,0,0,0,0,0,1,1); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(0,1,5,0,1,0,1,5,1,0,1,1); vv.exp = C_LU;   vq.push_back(vv);
    vv.stim = mk(0,0,0,0,0,0,0,0,0,0,0,1); vv.exp = C_IDLE; vq.push_back(vv);
    vv.stim = mk(1,1,5,0,1,0,1,5,1,1,1,0); vv.exp = C_IDLE; vq.push_back(vv);
    for (int i = 0; i < vq.size(); i++) begin
      do_reset();
      step(vq[i].stim, vq[i].exp, $sformatf("vec%0d", i));
    end

    // load-use stalls one cycle; x0 never interlocks
    do_reset();
    step(mk(0,1,0,5,0,1,1,5,1,0,0,0), C_LU, "lu_stall");
    step(mk(0,1,0,5,0,1,0,0,0,0,0,0), C_IDLE, "lu_release");
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    step(mk(0,1,0,0,0,1,1,0,1,0,0,0), C_IDLE, "lu_x0");
    chk("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // redirect drain
    do_reset();
    step(mk(0,0,0,0,0,0,0,0,0,1,0,0), C_RED, "redir_c0");
    step(idle(), C_DRN, "redir_c1");
    step(idle(), C_IDLE, "redir_c2");
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd2);

    // memory wait of 4, released in the ack cycle
    do_reset();
    for (int i = 0; i < 4; i++) step(waitv(), C_WAIT, $sformatf("mw_hold%0d", i));
    step(mk(0,0,0,0,0,0,0,0,0,0,1,1), C_IDLE, "mw_ack");
    step(idle(), C_IDLE, "mw_after");
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);

    // memory wait inside the drain freezes it
    do_reset();
    step(mk(0,0,0,0,0,0,0,0,0,1,0,0), C_RED, "dw_redir");
    for (int i = 0; i < 3; i++) step(waitv(), C_WAIT, $sformatf("dw_hold%0d", i));
    step(mk(0,0,0,0,0,0,0,0,0,0,1,1), C_DRN, "dw_ack_flush");
    step(idle(), C_IDLE, "dw_run");
    chk("dw_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("dw_stall_cnt", 32'(stall_cnt), 32'd3);

    // timeout after 8 wait cycles, sticky through ack
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(waitv(), C_WAIT, $sformatf("to_hold%0d", i));
      chk($sformatf("to_flag%0d", i), 32'(timeout), (i >= TO) ? 32'd1 : 32'd0);
    end
    step(mk(0,0,0,0,0,0,0,0,0,0,1,1), C_IDLE, "to_ack");
    chk("to_sticky", 32'(timeout), 32'd1);

    // reset in the middle of a wait
    step(waitv(), C_WAIT, "rw_hold0");
    step(waitv(), C_WAIT, "rw_hold1");
    step(mk(1,0,0,0,0,0,0,0,0,0,1,0), C_IDLE, "rw_rst");
    chk("rw_stall", 32'(stall_cnt), 32'd0);
    chk("rw_flush", 32'(flush_cnt), 32'd0);
    chk("rw_timeout", 32'(timeout), 32'd0);
    step(idle(), C_IDLE, "rw_run");

    // counter saturation
    do_reset();
    for (int i = 0; i < 40; i++) step(waitv(), C_WAIT, "sat_hold");
    chk("sat_stall", 32'(stall_cnt), 32'(CMAX));
    step(mk(0,0,0,0,0,0,0,0,0,0,1,1), C_IDLE, "sat_ack");
    for (int i = 0; i < 40; i++) step(mk(0,0,0,0,0,0,0,0,0,1,0,0), C_RED, "sat_redir");
    chk("sat_flush", 32'(flush_cnt), 32'(CMAX));

    // randomized traffic against the model
    do_reset();
    model_step(mk(1,0,0,0,0,0,0,0,0,0,0,0), e);
    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(0, 149) == 0);
      v.idv   = ($urandom_range(0, 3) != 0);
      v.rs1   = AW'($urandom_range(0, 3));
      v.rs2   = AW'($urandom_range(0, 3));
      v.u1    = $urandom_range(0, 1) != 0;
      v.u2    = $urandom_range(0, 1) != 0;
      v.exv   = ($urandom_range(0, 3) != 0);
      v.rd    = AW'($urandom_range(0, 3));
      v.ld    = $urandom_range(0, 1) != 0;
      v.redir = ($urandom_range(0, 7) == 0);
      v.req   = ($urandom_range(0, 5) == 0);
      v.ack   = ($urandom_range(0, 4) == 0);
      drive(v);
      @(negedge clk);
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("rnd_flush_cnt", 32'(flush_cnt), 32'(m_flush));
      chk("rnd_timeout", 32'(timeout), 32'(m_to));
      model_step(v, e);
      chk("rnd_ctrl", 32'(ctrl), 32'(e));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
